// File: rtl/modexp_engine.sv
// modexp_engine: result = message^exponent mod modulus.
// Left-to-right binary square-and-multiply over all EXP_WIDTH exponent bits,
// with a bit-serial interleaved (shift/add/reduce) modular multiplier.
// Each multiply takes exactly WIDTH cycles, so the latency from the start
// edge to done is 2 + WIDTH*(EXP_WIDTH + popcount(exponent)).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request, sampled only in IDLE
//   abort    synchronous cancel of a running operation
//   message  base (WIDTH), captured at start
//   exponent exponent (EXP_WIDTH), captured at start
//   modulus  modulus (WIDTH), captured at start
//   result   final value, held until the next completion
//   done     one-cycle completion pulse
//   error    valid with done; high when operands were rejected
//   busy     high from an accepted start until done or abort
module modexp_engine #(
    parameter int WIDTH     = 4096,
    parameter int EXP_WIDTH = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     message,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 error,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int JW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [JW-1:0] J_TOP    = JW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_n_s;

    logic [WIDTH-1:0]     msg_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [WIDTH-1:0]     mod_r;
    logic [WIDTH-1:0]     a_r;      // square-and-multiply accumulator
    logic [WIDTH-1:0]     x_sh_r;   // multiplier operand, consumed MSB first
    logic [WIDTH+1:0]     r_r;      // partial product, always < modulus
    logic [CW-1:0]        cnt_r;    // bit position inside the current multiply
    logic [JW-1:0]        j_r;      // exponent bit index
    logic                 err_r;    // operand rejection latched in CHECK

    logic                 bad_s;
    logic                 mul_last_s;
    logic [WIDTH-1:0]     a_init_s;
    logic [WIDTH+1:0]     m_ext_s;
    logic [WIDTH+1:0]     y_s;
    logic [WIDTH+1:0]     dbl_s;
    logic [WIDTH+1:0]     red_s;
    logic [WIDTH+1:0]     sum_s;
    logic [WIDTH+1:0]     r_next_s;

    // Operand validity and multiply bookkeeping.
    always_comb begin
        bad_s      = (mod_r == {WIDTH{1'b0}}) || (msg_r >= mod_r);
        mul_last_s = (cnt_r == CNT_LAST);
        if (mod_r == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            a_init_s = {WIDTH{1'b0}};
        end else begin
            a_init_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // One interleaved multiply step: R = 2R mod M, then R = R + x_i*Y mod M.
    always_comb begin
        m_ext_s = {2'b00, mod_r};
        if (state_r == MUL) begin
            y_s = {2'b00, msg_r};
        end else begin
            y_s = {2'b00, a_r};
        end
        // r_r < M < 2^WIDTH, so the shift never loses a set bit
        dbl_s = r_r << 1;
        if (dbl_s >= m_ext_s) begin
            red_s = dbl_s - m_ext_s;
        end else begin
            red_s = dbl_s;
        end
        if (x_sh_r[WIDTH-1]) begin
            sum_s = red_s + y_s;
        end else begin
            sum_s = red_s;
        end
        if (sum_s >= m_ext_s) begin
            r_next_s = sum_s - m_ext_s;
        end else begin
            r_next_s = sum_s;
        end
    end

    // Next-state logic; abort pulls any non-idle state back to IDLE.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = CHECK;
                end else begin
                    state_n_s = IDLE;
                end
            end
            CHECK: begin
                if (bad_s) begin
                    state_n_s = FIN;
                end else begin
                    state_n_s = SQR;
                end
            end
            SQR: begin
                if (!mul_last_s) begin
                    state_n_s = SQR;
                end else if (exp_r[j_r]) begin
                    state_n_s = MUL;
                end else if (j_r == {JW{1'b0}}) begin
                    state_n_s = FIN;
                end else begin
                    state_n_s = SQR;
                end
            end
            MUL: begin
                if (!mul_last_s) begin
                    state_n_s = MUL;
                end else if (j_r == {JW{1'b0}}) begin
                    state_n_s = FIN;
                end else begin
                    state_n_s = SQR;
                end
            end
            FIN: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
        if (abort && (state_r != IDLE)) begin
            state_n_s = IDLE;
        end else begin
            state_n_s = state_n_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Operand capture, multiplier datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_r  <= {WIDTH{1'b0}};
            exp_r  <= {EXP_WIDTH{1'b0}};
            mod_r  <= {WIDTH{1'b0}};
            a_r    <= {WIDTH{1'b0}};
            x_sh_r <= {WIDTH{1'b0}};
            r_r    <= {(WIDTH+2){1'b0}};
            cnt_r  <= {CW{1'b0}};
            j_r    <= {JW{1'b0}};
            err_r  <= 1'b0;
            result <= {WIDTH{1'b0}};
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                busy <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            msg_r <= message;
                            exp_r <= exponent;
                            mod_r <= modulus;
                            busy  <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                        end
                    end
                    CHECK: begin
                        err_r  <= bad_s;
                        a_r    <= a_init_s;
                        x_sh_r <= a_init_s;
                        r_r    <= {(WIDTH+2){1'b0}};
                        cnt_r  <= {CW{1'b0}};
                        j_r    <= J_TOP;
                    end
                    SQR, MUL: begin
                        if (mul_last_s) begin
                            // product done: it becomes A and the next X operand
                            a_r    <= r_next_s[WIDTH-1:0];
                            x_sh_r <= r_next_s[WIDTH-1:0];
                            r_r    <= {(WIDTH+2){1'b0}};
                            cnt_r  <= {CW{1'b0}};
                            if (state_n_s == SQR) begin
                                j_r <= j_r - {{(JW-1){1'b0}}, 1'b1};
                            end else begin
                                j_r <= j_r;
                            end
                        end else begin
                            x_sh_r <= {x_sh_r[WIDTH-2:0], 1'b0};
                            r_r    <= r_next_s;
                            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        error <= err_r;
                        busy  <= 1'b0;
                        if (err_r) begin
                            result <= {WIDTH{1'b0}};
                        end else begin
                            result <= a_r;
                        end
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modexp_engine.sv
// Directed bench for modexp_engine at WIDTH=EXP_WIDTH=8.
// Expected values are hand-computed modular powers; latency is
// 2 + 8*(8 + popcount(exponent)) cycles from the start edge.
module tb_modexp_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] message;
    logic [7:0] exponent;
    logic [7:0] modulus;
    logic [7:0] result;
    logic       done;
    logic       error;
    logic       busy;

    int checks;
    int errors;

    modexp_engine #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .message  (message),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .done     (done),
        .error    (error),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a job and wait for done. Latency counts edges after the start edge;
    // bcnt counts sampled busy-high cycles starting with the start edge.
    // now_flag=1 drives start immediately (used right after a done sample).
    task automatic run_job(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                           input bit with_abort, input bit now_flag,
                           output int lat, output int bcnt,
                           output logic [7:0] res, output logic err);
        if (!now_flag) @(negedge clk);
        message = m; exponent = e; modulus = n; start = 1'b1; abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        res = result;
        err = error;
    endtask

    task automatic test_reset();
        checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_encrypt();
        int lat, bcnt; logic [7:0] res; logic err;
        run_job(8'd8, 8'd13, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd50) begin errors++; $display("FAIL enc_result got %0d want 50", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL enc_error got %b want 0", err); end
        checks++; if (lat != 90) begin errors++; $display("FAIL enc_latency got %0d want 90", lat); end
        checks++; if (bcnt != 90) begin errors++; $display("FAIL enc_busy_cycles got %0d want 90", bcnt); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL enc_done_pulse got %b want 0", done); end
    endtask

    task automatic test_decrypt();
        int lat, bcnt; logic [7:0] res; logic err;
        run_job(8'd50, 8'd37, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd8) begin errors++; $display("FAIL dec_result got %0d want 8", res); end
        checks++; if (lat != 90) begin errors++; $display("FAIL dec_latency got %0d want 90", lat); end
    endtask

    task automatic test_operand_errors();
        int lat, bcnt; logic [7:0] res; logic err;
        run_job(8'd8, 8'd13, 8'd0, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mod0_error got %b want 1", err); end
        checks++; if (res !== 8'd0) begin errors++; $display("FAIL mod0_result got %0d want 0", res); end
        checks++; if (lat != 2) begin errors++; $display("FAIL mod0_latency got %0d want 2", lat); end
        run_job(8'd77, 8'd13, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL msg_ge_mod_error got %b want 1", err); end
        checks++; if (lat != 2) begin errors++; $display("FAIL msg_ge_mod_latency got %0d want 2", lat); end
        // modulus 1: popcount(5)=2 -> 2 + 8*10 = 82
        run_job(8'd0, 8'd5, 8'd1, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd0) begin errors++; $display("FAIL mod1_result got %0d want 0", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mod1_error got %b want 0", err); end
        checks++; if (lat != 82) begin errors++; $display("FAIL mod1_latency got %0d want 82", lat); end
    endtask

    task automatic test_exponent_edges();
        int lat, bcnt; logic [7:0] res; logic err;
        run_job(8'd8, 8'd0, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd1) begin errors++; $display("FAIL exp0_result got %0d want 1", res); end
        checks++; if (lat != 66) begin errors++; $display("FAIL exp0_latency got %0d want 66", lat); end
        // 8 has order 10 mod 77, so 8^255 = 8^5 = 43 mod 77
        run_job(8'd8, 8'hFF, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd43) begin errors++; $display("FAIL expff_result got %0d want 43", res); end
        checks++; if (lat != 130) begin errors++; $display("FAIL expff_latency got %0d want 130", lat); end
    endtask

    task automatic test_abort();
        int lat, bcnt; logic [7:0] res; logic err; logic [7:0] prev; int seen;
        prev = result;
        @(negedge clk);
        message = 8'd8; exponent = 8'd13; modulus = 8'd77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        seen = 0;
        repeat (120) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
        checks++; if (result !== prev) begin errors++; $display("FAIL abort_result got %0d want %0d", result, prev); end
        // abort alone in IDLE does nothing
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_abort_busy got %b want 0", busy); end
        // start and abort together in IDLE: start wins
        run_job(8'd8, 8'd13, 8'd77, 1'b1, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd50) begin errors++; $display("FAIL start_abort_result got %0d want 50", res); end
        checks++; if (lat != 90) begin errors++; $display("FAIL start_abort_latency got %0d want 90", lat); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        message = 8'd8; exponent = 8'd13; modulus = 8'd77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        repeat (19) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        message = 8'd3; exponent = 8'hFF; modulus = 8'd11; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat++;
        while (!done && lat < 400) begin @(posedge clk); #1; lat++; end
        checks++; if (result !== 8'd50) begin errors++; $display("FAIL ignored_start_result got %0d want 50", result); end
        checks++; if (lat != 90) begin errors++; $display("FAIL ignored_start_latency got %0d want 90", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; logic [7:0] res; logic err;
        run_job(8'd8, 8'd13, 8'd77, 1'b0, 1'b0, lat, bcnt, res, err);
        checks++; if (res !== 8'd50) begin errors++; $display("FAIL b2b_first_result got %0d want 50", res); end
        // start raised during the done cycle is accepted at the very next edge
        run_job(8'd50, 8'd37, 8'd77, 1'b0, 1'b1, lat, bcnt, res, err);
        checks++; if (bcnt != 90) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 90", bcnt); end
        checks++; if (res !== 8'd8) begin errors++; $display("FAIL b2b_second_result got %0d want 8", res); end
        checks++; if (lat != 90) begin errors++; $display("FAIL b2b_latency got %0d want 90", lat); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        message = 8'd8; exponent = 8'd13; modulus = 8'd77; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (30) @(posedge clk);
        #2; reset = 1'b1; #1;
        checks++; if ({result, done, error, busy} !== 11'd0)
            begin errors++; $display("FAIL midreset_outputs got %h want 0", {result, done, error, busy}); end
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (100) begin @(posedge clk); #1; if (done || busy) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles want 0", seen); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        message = 8'd0; exponent = 8'd0; modulus = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset = 1'b0;
        test_encrypt();
        test_decrypt();
        test_operand_errors();
        test_exponent_edges();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
